// File: rtl/mdu_ctrl_if.sv
// Port bundle between the E-stage issue logic / hazard unit and the MDU sequencer.
// start is a one-cycle issue strobe with no ready: the hazard unit holds MDU ops in D while busy|stall_md.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        md_use_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [0:0]  state;

    modport master (
        output start, md_op, rs_e, rt_e, md_use_d,
        input  busy, stall_md, hi, lo, state
    );

    modport slave (
        input  start, md_op, rs_e, rt_e, md_use_d,
        output busy, stall_md, hi, lo, state
    );
endinterface

// File: rtl/mdu_ctrl.sv
// MIPS E-stage multiply/divide sequencer: computes the result at issue, counts a fixed
// busy latency, then commits to HI/LO. MTHI/MTLO write directly without going busy.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset_n,
    mdu_ctrl_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state;
    logic [3:0]  count;
    logic [31:0] hi_q, lo_q;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_we;

    logic        is_md, is_div, div_zero;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, divisor, quo, rem;
    logic [63:0] sprod, uprod;
    logic [31:0] res_hi, res_lo;

    assign is_md    = (bus.md_op <= 3'd3);
    assign is_div   = (bus.md_op == 3'd2) || (bus.md_op == 3'd3);
    assign div_zero = (bus.rt_e == 32'd0);

    // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        a_neg   = (bus.md_op == 3'd2) && bus.rs_e[31];
        b_neg   = (bus.md_op == 3'd2) && bus.rt_e[31];
        a_mag   = a_neg ? (32'd0 - bus.rs_e) : bus.rs_e;
        b_mag   = b_neg ? (32'd0 - bus.rt_e) : bus.rt_e;
        divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
        quo     = a_mag / divisor;
        rem     = a_mag % divisor;
        sprod   = $signed({{32{bus.rs_e[31]}}, bus.rs_e}) * $signed({{32{bus.rt_e[31]}}, bus.rt_e});
        uprod   = {32'd0, bus.rs_e} * {32'd0, bus.rt_e};
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        if (is_div) begin
            res_lo = (a_neg ^ b_neg) ? (32'd0 - quo) : quo;
            res_hi = a_neg ? (32'd0 - rem) : rem;
        end else if (bus.md_op[0]) begin
            {res_hi, res_lo} = uprod;
        end else begin
            {res_hi, res_lo} = sprod;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            count   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_we <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (is_md) begin
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            pend_we <= !(is_div && div_zero);
                            count   <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                            state   <= RUN;
                        end else if (bus.md_op == 3'd4) begin
                            hi_q <= bus.rs_e;
                        end else if (bus.md_op == 3'd5) begin
                            lo_q <= bus.rs_e;
                        end
                    end
                end
                RUN: begin
                    // A start arriving here is a hazard-unit bug and is deliberately dropped.
                    if (count == 4'd1) begin
                        if (pend_we) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                        count <= 4'd0;
                        state <= IDLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= 4'd0;
                end
            endcase
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.stall_md = bus.md_use_d & ((state == RUN) | (bus.start & is_md));
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.state    = state;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed cases plus random ops against an arithmetic reference model;
// commits are checked by a monitor popping an expected {hi,lo} queue when busy falls.
module tb_mdu_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    mdu_ctrl_if bus();

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int flagged = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results from plain 64-bit arithmetic; returns {hi,lo}.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, output bit wr);
        longint sa, sb, q, r;
        logic [63:0] res;
        wr = 1'b1;
        res = 64'd0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: res = 64'(sa * sb);
            3'd1: res = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) wr = 1'b0;
                else begin
                    q = sa / sb;
                    r = sa - q * sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) wr = 1'b0;
                else res = {a % b, a / b};
            end
            default: wr = 1'b0;
        endcase
        return res;
    endfunction

    // Monitor: a falling busy edge is the DUT presenting a committed result.
    initial begin
        logic prev_busy;
        logic [63:0] exp;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk or negedge reset_n);
            if (!reset_n) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !bus.busy) begin
                    if (exp_q.size() == 0) begin
                        check("commit_unexpected", 64'(1), 64'(0));
                    end else begin
                        exp = exp_q.pop_front();
                        check("commit_hilo", {bus.hi, bus.lo}, exp);
                    end
                end
                prev_busy = bus.busy;
            end
        end
    end

    // Called and returns just after a falling edge with the unit idle.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d, input bit inject);
        logic [31:0] old_hi, old_lo;
        logic [63:0] r;
        bit wr;
        int n;
        old_hi = m_hi;
        old_lo = m_lo;
        bus.start = 1'b1;
        bus.md_op = op;
        bus.rs_e = a;
        bus.rt_e = b;
        bus.md_use_d = use_d;
        #1;
        check("stall_issue", 64'(bus.stall_md), 64'(use_d && (op <= 3'd3)));
        if (op <= 3'd3) begin
            r = ref_result(op, a, b, wr);
            if (wr) begin
                m_hi = r[63:32];
                m_lo = r[31:0];
            end
            exp_q.push_back({m_hi, m_lo});
            n = (op <= 3'd1) ? MULT_N : DIV_N;
            for (int i = 1; i <= n; i++) begin
                @(negedge clk);
                bus.start = 1'b0;
                if (inject && i == 3) begin
                    bus.start = 1'b1;
                    bus.md_op = 3'($urandom_range(0, 5));
                    bus.rs_e = $urandom;
                    bus.rt_e = $urandom;
                    flagged++;
                    $display("note: start asserted during busy cycle %0d, expected to be ignored", i);
                end
                #1;
                check("busy_run", 64'(bus.busy), 64'(1));
                check("stall_run", 64'(bus.stall_md), 64'(use_d));
                check("hold_hi", 64'(bus.hi), 64'(old_hi));
                check("hold_lo", 64'(bus.lo), 64'(old_lo));
            end
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            check("busy_done", 64'(bus.busy), 64'(0));
            check("stall_done", 64'(bus.stall_md), 64'(0));
        end else begin
            if (op == 3'd4) m_hi = a;
            else if (op == 3'd5) m_lo = a;
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            check("busy_mt", 64'(bus.busy), 64'(0));
            check("mt_hi", 64'(bus.hi), 64'(m_hi));
            check("mt_lo", 64'(bus.lo), 64'(m_lo));
        end
        bus.md_use_d = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] op;
        logic [31:0] a, b;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        bus.rs_e = 32'd0;
        bus.rt_e = 32'd0;
        bus.md_use_d = 1'b1;
        #3;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_stall", 64'(bus.stall_md), 64'(0));
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        bus.md_use_d = 1'b0;
        #20;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        check("tp1_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFA);
        do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        check("tp2_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
        do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        check("tp3_div", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
        do_op(3'd4, 32'h11, 32'd0, 1'b0, 1'b0);
        do_op(3'd5, 32'h22, 32'd0, 1'b0, 1'b0);
        do_op(3'd3, 32'd7, 32'd0, 1'b0, 1'b0);
        check("tp3_div0", {bus.hi, bus.lo}, 64'h00000011_00000022);
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        check("div_ovf", {bus.hi, bus.lo}, 64'h00000000_80000000);
        do_op(3'd0, 32'd1234, 32'd5678, 1'b1, 1'b0);
        do_op(3'd5, 32'h1234, 32'd0, 1'b1, 1'b0);
        check("tp4_mtlo", 64'(bus.lo), 64'h1234);
        do_op(3'd6, 32'hDEADBEEF, 32'd1, 1'b1, 1'b0);

        // Reset in busy cycle 4 of a DIV aborts with no later commit
        bus.start = 1'b1;
        bus.md_op = 3'd2;
        bus.rs_e = 32'd100;
        bus.rt_e = 32'd7;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'(0));
        check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_busy", 64'(bus.busy), 64'(0));
            check("post_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        end

        // Back-to-back: DIV then MTHI right after commit; then DIV with a stray start
        do_op(3'd2, 32'd100, 32'd7, 1'b0, 1'b0);
        do_op(3'd4, 32'hCAFE0001, 32'd0, 1'b0, 1'b0);
        check("tp6_hilo", {bus.hi, bus.lo}, 64'hCAFE0001_0000000E);
        do_op(3'd2, 32'd1000, 32'hFFFFFFFD, 1'b1, 1'b1);

        // Random ops
        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            do_op(op, a, b, 1'($urandom_range(0, 1)), (op <= 3'd3) && ($urandom_range(0, 4) == 0));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("note: %0d stray start pulses injected during busy", flagged);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
